// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPEEX  = 4'd6,
      RTYPEWB  = 4'd7,
      BRANCH   = 4'd8,
      IMMEX    = 4'd9,
      IMMWB    = 4'd10,
      JUMP     = 4'd11
   } statetype;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // ALU operations
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Immediate forms
   localparam logic [1:0] IMM_SIGN = 2'b00;
   localparam logic [1:0] IMM_ZERO = 2'b01;
   localparam logic [1:0] IMM_LUI  = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_4     = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BRIMM = 2'b11;

   // Next-PC select
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // I-type ALU instructions that share the IMMEX/IMMWB path
   function automatic logic is_imm_alu(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
             (op == OP_SLTI) || (op == OP_LUI);
   endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// R-type funct decoder: maps funct to the ALU operation, add for anything unknown.
module mips_mc_aludec
   import mips_mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   // Pure lookup; unlisted functs behave as add
   always_comb begin
      alucontrol = ALU_ADD;
      case (funct)
         FUNCT_ADD: alucontrol = ALU_ADD;
         FUNCT_SUB: alucontrol = ALU_SUB;
         FUNCT_AND: alucontrol = ALU_AND;
         FUNCT_OR:  alucontrol = ALU_OR;
         FUNCT_SLT: alucontrol = ALU_SLT;
         default:   alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the multicycle MIPS datapath; pcen is the only output that sees zero.
module mips_mc_controller
   import mips_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       retire
);

   statetype   state_q, state_d;
   statetype   ostate;
   logic [2:0] rtype_alu;
   logic       pcwrite, branch, isbne;

   mips_mc_aludec u_aludec (
      .funct      (funct),
      .alucontrol (rtype_alu)
   );

   // State register; synchronous reset returns to FETCH
   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Next state and Moore outputs. During reset the outputs are decoded as FETCH
   // and every enable is then forced low, so nothing is written in the abort cycle.
   always_comb begin
      state_d    = FETCH;
      ostate     = reset ? FETCH : state_q;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = SRCB_B;
      immsrc     = IMM_SIGN;
      pcsrc      = PC_ALU;
      alucontrol = ALU_ADD;
      retire     = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      isbne      = 1'b0;
      pcen       = 1'b0;

      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE: begin
            if ((op == OP_LW) || (op == OP_SW))       state_d = MEMADR;
            else if (op == OP_RTYPE)                  state_d = RTYPEEX;
            else if ((op == OP_BEQ) || (op == OP_BNE)) state_d = BRANCH;
            else if (is_imm_alu(op))                  state_d = IMMEX;
            else if (op == OP_J)                      state_d = JUMP;
            else                                      state_d = FETCH;
         end
         MEMADR: begin
            if (op == OP_LW)      state_d = MEMRD;
            else if (op == OP_SW) state_d = MEMWR;
            else                  state_d = FETCH;
         end
         MEMRD:   state_d = MEMWB;
         RTYPEEX: state_d = RTYPEWB;
         IMMEX:   state_d = IMMWB;
         default: state_d = FETCH;
      endcase

      case (ostate)
         FETCH: begin
            irwrite = 1'b1;
            alusrcb = SRCB_4;
            pcwrite = 1'b1;
         end
         DECODE: begin
            alusrcb = SRCB_BRIMM;
            retire  = !((op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                        (op == OP_BEQ) || (op == OP_BNE) || is_imm_alu(op) ||
                        (op == OP_J));
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         MEMRD: iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            retire   = 1'b1;
         end
         RTYPEEX: begin
            alusrca    = 1'b1;
            alucontrol = rtype_alu;
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         BRANCH: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = PC_ALUOUT;
            branch     = 1'b1;
            isbne      = (op == OP_BNE);
            retire     = 1'b1;
         end
         IMMEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            case (op)
               OP_ANDI: begin immsrc = IMM_ZERO; alucontrol = ALU_AND; end
               OP_ORI:  begin immsrc = IMM_ZERO; alucontrol = ALU_OR;  end
               OP_SLTI: alucontrol = ALU_SLT;
               OP_LUI:  immsrc = IMM_LUI;
               default: ;
            endcase
         end
         IMMWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
         end
         JUMP: begin
            pcsrc   = PC_JUMP;
            pcwrite = 1'b1;
            retire  = 1'b1;
         end
         default: ;
      endcase

      pcen = pcwrite | (branch & (zero ^ isbne));

      if (reset) begin
         pcen     = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         retire   = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle vector table plus reset and latency sequences.
module tb_mips_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
   logic [1:0] alusrcb, immsrc, pcsrc;
   logic [2:0] alucontrol;
   logic       retire;
   logic [17:0] got;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic [17:0] exp;
   } vec_t;

   vec_t vecs[$];

   logic [17:0] RST, F, D, DN, MA, MR, MWB, MWR, RWB, IWB, J;

   mips_mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .immsrc     (immsrc),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .retire     (retire)
   );

   always #5 clk = ~clk;

   assign got = {pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                 alusrcb, immsrc, pcsrc, alucontrol, retire};

   // Packs one expected output word in the same order as got
   function automatic logic [17:0] o(input logic pe, input logic io, input logic mw,
                                     input logic irw, input logic rw, input logic rd,
                                     input logic mtr, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] imm, input logic [1:0] pcs,
                                     input logic [2:0] alu, input logic ret);
      return {pe, io, mw, irw, rw, rd, mtr, asa, asb, imm, pcs, alu, ret};
   endfunction

   task automatic add(input string name, input logic rst, input logic [5:0] op_v,
                      input logic [5:0] fn_v, input logic z, input logic [17:0] e);
      vec_t v;
      v.name = name; v.rst = rst; v.op = op_v; v.funct = fn_v; v.zero = z; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [17:0] g, input logic [17:0] e);
      n_cmp++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, g, e);
      end
   endtask

   task automatic check_int(input string name, input int unsigned g, input int unsigned e);
      n_cmp++;
      if (g != e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, g, e);
      end
   endtask

   task automatic apply(input logic rst, input logic [5:0] op_v, input logic [5:0] fn_v,
                        input logic z);
      reset = rst; op = op_v; funct = fn_v; zero = z;
      #2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction from FETCH, counting cycles up to retire and write pulses
   task automatic measure(input string name, input logic [5:0] op_v, input logic [5:0] fn_v,
                          input int unsigned exp_cyc, input int unsigned exp_wr);
      int unsigned cyc = 0;
      int unsigned wr  = 0;
      logic done = 1'b0;
      for (int i = 0; i < 8 && !done; i++) begin
         apply(1'b0, op_v, fn_v, 1'b0);
         cyc++;
         if (regwrite || memwrite) wr++;
         if (retire) done = 1'b1;
         step();
      end
      if (!done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s.retire: got none within 8 cycles expected retire", name);
      end else begin
         check_int({name, ".cycles"}, cyc, exp_cyc);
         check_int({name, ".writes"}, wr, exp_wr);
      end
   endtask

   initial begin
      RST = o(0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,3'b010,0);
      F   = o(1,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,3'b010,0);
      D   = o(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,3'b010,0);
      DN  = o(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,3'b010,1);
      MA  = o(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,3'b010,0);
      MR  = o(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b010,0);
      MWB = o(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,3'b010,1);
      MWR = o(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b010,1);
      RWB = o(0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,3'b010,1);
      IWB = o(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'b010,1);
      J   = o(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,3'b010,1);

      add("rst0", 1, 6'b100011, 6'h00, 1, RST);
      add("rst1", 1, 6'b100011, 6'h00, 0, RST);
      // lw: 5 cycles, zero held high to show it only matters in BRANCH
      add("lw.fetch",  0, 6'b100011, 6'h00, 1, F);
      add("lw.decode", 0, 6'b100011, 6'h00, 1, D);
      add("lw.memadr", 0, 6'b100011, 6'h00, 1, MA);
      add("lw.memrd",  0, 6'b100011, 6'h00, 1, MR);
      add("lw.memwb",  0, 6'b100011, 6'h00, 1, MWB);
      // sw
      add("sw.fetch",  0, 6'b101011, 6'h00, 0, F);
      add("sw.decode", 0, 6'b101011, 6'h00, 0, D);
      add("sw.memadr", 0, 6'b101011, 6'h00, 0, MA);
      add("sw.memwr",  0, 6'b101011, 6'h00, 0, MWR);
      // beq / bne with both zero values
      add("beq1.fetch",  0, 6'b000100, 6'h00, 1, F);
      add("beq1.decode", 0, 6'b000100, 6'h00, 1, D);
      add("beq1.branch", 0, 6'b000100, 6'h00, 1, o(1,0,0,0,0,0,0,1,2'b00,2'b00,2'b01,3'b110,1));
      add("beq0.fetch",  0, 6'b000100, 6'h00, 0, F);
      add("beq0.decode", 0, 6'b000100, 6'h00, 0, D);
      add("beq0.branch", 0, 6'b000100, 6'h00, 0, o(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b01,3'b110,1));
      add("bne1.fetch",  0, 6'b000101, 6'h00, 1, F);
      add("bne1.decode", 0, 6'b000101, 6'h00, 1, D);
      add("bne1.branch", 0, 6'b000101, 6'h00, 1, o(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b01,3'b110,1));
      add("bne0.fetch",  0, 6'b000101, 6'h00, 0, F);
      add("bne0.decode", 0, 6'b000101, 6'h00, 0, D);
      add("bne0.branch", 0, 6'b000101, 6'h00, 0, o(1,0,0,0,0,0,0,1,2'b00,2'b00,2'b01,3'b110,1));
      // I-type ALU forms
      add("ori.fetch",  0, 6'b001101, 6'h00, 0, F);
      add("ori.decode", 0, 6'b001101, 6'h00, 0, D);
      add("ori.immex",  0, 6'b001101, 6'h00, 0, o(0,0,0,0,0,0,0,1,2'b10,2'b01,2'b00,3'b001,0));
      add("ori.immwb",  0, 6'b001101, 6'h00, 0, IWB);
      add("lui.fetch",  0, 6'b001111, 6'h00, 0, F);
      add("lui.decode", 0, 6'b001111, 6'h00, 0, D);
      add("lui.immex",  0, 6'b001111, 6'h00, 0, o(0,0,0,0,0,0,0,1,2'b10,2'b10,2'b00,3'b010,0));
      add("lui.immwb",  0, 6'b001111, 6'h00, 0, IWB);
      add("andi.fetch",  0, 6'b001100, 6'h00, 0, F);
      add("andi.decode", 0, 6'b001100, 6'h00, 0, D);
      add("andi.immex",  0, 6'b001100, 6'h00, 0, o(0,0,0,0,0,0,0,1,2'b10,2'b01,2'b00,3'b000,0));
      add("andi.immwb",  0, 6'b001100, 6'h00, 0, IWB);
      add("slti.fetch",  0, 6'b001010, 6'h00, 0, F);
      add("slti.decode", 0, 6'b001010, 6'h00, 0, D);
      add("slti.immex",  0, 6'b001010, 6'h00, 0, o(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,3'b111,0));
      add("slti.immwb",  0, 6'b001010, 6'h00, 0, IWB);
      add("addi.fetch",  0, 6'b001000, 6'h00, 0, F);
      add("addi.decode", 0, 6'b001000, 6'h00, 0, D);
      add("addi.immex",  0, 6'b001000, 6'h00, 0, o(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,3'b010,0));
      add("addi.immwb",  0, 6'b001000, 6'h00, 0, IWB);
      // R-type funct decode
      add("slt.fetch",  0, 6'b000000, 6'b101010, 0, F);
      add("slt.decode", 0, 6'b000000, 6'b101010, 0, D);
      add("slt.rex",    0, 6'b000000, 6'b101010, 0, o(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b111,0));
      add("slt.rwb",    0, 6'b000000, 6'b101010, 0, RWB);
      add("sub.fetch",  0, 6'b000000, 6'b100010, 0, F);
      add("sub.decode", 0, 6'b000000, 6'b100010, 0, D);
      add("sub.rex",    0, 6'b000000, 6'b100010, 0, o(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b110,0));
      add("sub.rwb",    0, 6'b000000, 6'b100010, 0, RWB);
      add("or.fetch",   0, 6'b000000, 6'b100101, 0, F);
      add("or.decode",  0, 6'b000000, 6'b100101, 0, D);
      add("or.rex",     0, 6'b000000, 6'b100101, 0, o(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b001,0));
      add("or.rwb",     0, 6'b000000, 6'b100101, 0, RWB);
      add("f3f.fetch",  0, 6'b000000, 6'b111111, 0, F);
      add("f3f.decode", 0, 6'b000000, 6'b111111, 0, D);
      add("f3f.rex",    0, 6'b000000, 6'b111111, 0, o(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b010,0));
      add("f3f.rwb",    0, 6'b000000, 6'b111111, 0, RWB);
      // jump and unknown op
      add("j.fetch",   0, 6'b000010, 6'h00, 0, F);
      add("j.decode",  0, 6'b000010, 6'h00, 0, D);
      add("j.jump",    0, 6'b000010, 6'h00, 0, J);
      add("unk.fetch", 0, 6'b111111, 6'h00, 0, F);
      add("unk.decode",0, 6'b111111, 6'h00, 0, DN);
      add("unk.next",  0, 6'b100011, 6'h00, 0, F);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero);
         check(vecs[i].name, got, vecs[i].exp);
         step();
      end
      // Table ends after the FETCH of a lw; finish that lw so the FSM is back in FETCH
      apply(0, 6'b100011, 6'h00, 0); step();
      apply(0, 6'b100011, 6'h00, 0); step();
      apply(0, 6'b100011, 6'h00, 0); step();
      apply(0, 6'b100011, 6'h00, 0); step();

      // Reset in the middle of MEMRD aborts the lw without a register write
      apply(0, 6'b100011, 6'h00, 0); check("abort.fetch",  got, F);  step();
      apply(0, 6'b100011, 6'h00, 0); check("abort.decode", got, D);  step();
      apply(0, 6'b100011, 6'h00, 0); check("abort.memadr", got, MA); step();
      apply(1, 6'b100011, 6'h00, 0); check("abort.rst",    got, RST); step();
      apply(0, 6'b100011, 6'h00, 0); check("abort.refetch",got, F);  step();
      apply(0, 6'b100011, 6'h00, 0); check("abort.redecode",got, D); step();
      apply(0, 6'b100011, 6'h00, 0); check("abort.remadr", got, MA); step();
      apply(0, 6'b100011, 6'h00, 0); check("abort.rememrd",got, MR); step();
      apply(0, 6'b100011, 6'h00, 0); check("abort.rememwb",got, MWB); step();

      // Cycles per instruction and number of write-enable cycles
      measure("cpi.lw",  6'b100011, 6'h00,     5, 1);
      measure("cpi.sw",  6'b101011, 6'h00,     4, 1);
      measure("cpi.add", 6'b000000, 6'b100000, 4, 1);
      measure("cpi.ori", 6'b001101, 6'h00,     4, 1);
      measure("cpi.beq", 6'b000100, 6'h00,     3, 0);
      measure("cpi.j",   6'b000010, 6'h00,     3, 0);
      measure("cpi.unk", 6'b111111, 6'h00,     2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
